class_argmax: RTL and testbench
===============================

# class_argmax

Output-layer classifier stage placed directly after the per-neuron `DotProduct784` units. It accepts the biased 26-bit signed fixed-point neuron scores one per handshake, for classes 0..N_CLASSES-1 in order, and tracks the running maximum. After the last class it presents the winning class index, holding it until the consumer accepts it. It then re-arms for the next image.

## Interface
- `N_CLASSES`, default 10: scores per image, legal range 2..16.
- `SCORE_W`, default 26: score width; matches the dot-product `value` output.
- `IDX_W`, default `$clog2(N_CLASSES)`: class index width.
- `clk` input, 1 bit: sole clock; all state updates on its rising edge.
- `GlobalReset` input, 1 bit: reset, asynchronous and active-low.
- `clear` input, 1 bit: synchronous flush; discards a partial or held result.
- `in_valid` input, 1 bit: `in_score` is valid.
- `in_ready` output, 1 bit: block can accept a score; registered.
- `in_score` input, SCORE_W bits: signed two's-complement neuron score.
- `out_valid` output, 1 bit: result is valid; registered.
- `out_ready` input, 1 bit: consumer accepts the result.
- `out_class` output, IDX_W bits: index of the maximum score.
- `out_score` output, SCORE_W bits: maximum score (only with `CLASS_ARGMAX_SCORE_OUT_EN`).

## Operation
- FSM states:
  - ARM: the single cycle after reset release. Forces `in_ready` to 1, then moves to ACCUM.
  - ACCUM: collects scores.
  - DONE: holds the result.
- ACCUM:
  - An accept is `in_valid && in_ready`. Score k is the k-th accept since entering ACCUM; count register `cnt` runs 0..N_CLASSES-1.
  - k=0: `best_score`←`in_score`, `best_idx`←0, unconditionally.
  - k>0: replace only if `$signed(in_score) > $signed(best_score)` (strictly greater). Ties keep the lower index.
  - On accept with `cnt==N_CLASSES-1`: capture the final compare into `out_class`/`out_score`, set `out_valid`=1, clear `in_ready`, reset `cnt` to 0, go to DONE.
- DONE:
  - `out_*` are stable.
  - On `out_valid && out_ready`: `out_valid`←0, `in_ready`←1, go to ACCUM.
  - `in_valid` is ignored in DONE.
- `clear` (any state except reset): next cycle `cnt`=0, `out_valid`=0, `in_ready`=1, state ACCUM.
  - `clear` takes priority over a simultaneous input accept or output handshake; the accept is dropped.
  - `out_class`/`out_score` keep their last values.
- Compare is full-width signed with no saturation; all values −2^25..2^25−1 are valid.
- Async reset mid-image: partial result lost, no output produced.

## Timing
- Reset values: `in_ready`=0, `out_valid`=0, `out_class`=0, `out_score`=0, `cnt`=0, state ARM.
- `in_ready` rises on the first `clk` edge after `GlobalReset` deasserts.
- Throughput: one score per cycle in ACCUM with no bubbles.
- Latency: `out_valid` high on the cycle after the N-th accept.
- `in_ready` re-asserts the cycle after the output handshake. Minimum image period is N_CLASSES+1 cycles with `out_ready` tied high.
- `in_ready` and `out_valid` are never both 1.

## Configuration
- `CLASS_ARGMAX_SCORE_OUT_EN` defined: the `out_score` port exists and carries the winning score under the same valid/hold rules as `out_class`.
- Not defined: the `out_score` port and its output register are removed. `best_score` remains internal, since the compare needs it.

## Structure
- Shared package `nn_pkg`:
  - `N_CLASSES_DEF`=10 and `SCORE_W_DEF`=26.
  - `score_t` typedef.
  - `argmax_state_e` enum {ARM, ACCUM, DONE}.
- Sub-module `score_max_cmp`: purely combinational.
  - Inputs: candidate score/index, current best, `first` flag.
  - Outputs: next best score/index.
  - The FSM instantiates it once.

## Test plan
- N=10, scores 5,−3,100,7,100,0,−50,2,99,1 streamed back-to-back, `out_ready`=1 → `out_class`=2 (tie keeps lower index), `out_score`=100, `out_valid` one cycle after the 10th accept.
- All ten scores = −2^25 → `out_class`=0; then 0x1FFFFFF at index 9 → `out_class`=9 (signed compare checked).
- `out_ready` held low 20 cycles after result → `out_valid`/`out_class` stable, `in_ready`=0, extra `in_valid` pulses ignored; release → next image accepted the following cycle.
- `clear` asserted after 4 scores, together with an `in_valid` → that score dropped; next 10 scores yield a result over those 10 only.
- `GlobalReset` asserted mid-image, asynchronously between edges → outputs 0 immediately, `in_ready`=1 one edge after release, next 10 scores classified correctly.
- `in_valid` randomly gapped (about 50% duty) → same result as the back-to-back run, one result per 10 accepts.

Source files
------------

// File: rtl/class_argmax_pkg.sv
// Shared types for the output-layer classifier (package nn_pkg).
// Optional score output is selected by CLASS_ARGMAX_SCORE_OUT_EN.
package nn_pkg;

    localparam int N_CLASSES_DEF = 10;
    localparam int SCORE_W_DEF   = 26;

    typedef logic signed [SCORE_W_DEF-1:0] score_t;

    typedef enum logic [1:0] {
        ARM,
        ACCUM,
        DONE
    } argmax_state_e;

endpackage

// File: rtl/class_argmax_if.sv
// Score-in / class-out handshake bundle for class_argmax.
// out_score exists only when CLASS_ARGMAX_SCORE_OUT_EN is defined.
interface class_argmax_if
    import nn_pkg::*;
#(
    parameter int SCORE_W = SCORE_W_DEF,
    parameter int IDX_W   = $clog2(N_CLASSES_DEF)
);

    logic                      clear;
    logic                      in_valid;
    logic                      in_ready;
    logic signed [SCORE_W-1:0] in_score;
    logic                      out_valid;
    logic                      out_ready;
    logic [IDX_W-1:0]          out_class;

`ifdef CLASS_ARGMAX_SCORE_OUT_EN
    logic signed [SCORE_W-1:0] out_score;

    modport master (
        output clear, in_valid, in_score, out_ready,
        input  in_ready, out_valid, out_class, out_score
    );

    modport slave (
        input  clear, in_valid, in_score, out_ready,
        output in_ready, out_valid, out_class, out_score
    );
`else
    modport master (
        output clear, in_valid, in_score, out_ready,
        input  in_ready, out_valid, out_class
    );

    modport slave (
        input  clear, in_valid, in_score, out_ready,
        output in_ready, out_valid, out_class
    );
`endif

endinterface

// File: rtl/class_argmax_score_max_cmp.sv
// Combinational running-max step: picks candidate or current best.
// Ties keep the current best, so the lower class index wins.
module score_max_cmp #(
    parameter int SCORE_W = 26,
    parameter int IDX_W   = 4
) (
    input  logic signed [SCORE_W-1:0] cand_score,
    input  logic [IDX_W-1:0]          cand_idx,
    input  logic signed [SCORE_W-1:0] best_score,
    input  logic [IDX_W-1:0]          best_idx,
    input  logic                      first,
    output logic signed [SCORE_W-1:0] next_score,
    output logic [IDX_W-1:0]          next_idx
);

    always_comb begin
        next_score = best_score;
        next_idx   = best_idx;
        if (first || (cand_score > best_score)) begin
            next_score = cand_score;
            next_idx   = cand_idx;
        end
    end

endmodule

// File: rtl/class_argmax.sv
// Argmax over N_CLASSES streamed neuron scores; holds the winning index until taken.
// Define CLASS_ARGMAX_SCORE_OUT_EN to also export the winning score.
import nn_pkg::*;

module class_argmax #(
    parameter int N_CLASSES = N_CLASSES_DEF,
    parameter int SCORE_W   = SCORE_W_DEF,
    parameter int IDX_W     = $clog2(N_CLASSES)
) (
    input logic           clk,
    input logic           GlobalReset,
    class_argmax_if.slave bus
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

    argmax_state_e             state;
    logic [IDX_W-1:0]          cnt;
    logic signed [SCORE_W-1:0] best_score;
    logic [IDX_W-1:0]          best_idx;
    logic                      in_ready_q;
    logic                      out_valid_q;
    logic [IDX_W-1:0]          out_class_q;
    logic signed [SCORE_W-1:0] next_score;
    logic [IDX_W-1:0]          next_idx;
    logic                      accept;

    // in_ready is only ever high in ACCUM, so it alone qualifies an accept
    assign accept = bus.in_valid && in_ready_q;

    score_max_cmp #(
        .SCORE_W (SCORE_W),
        .IDX_W   (IDX_W)
    ) u_cmp (
        .cand_score (bus.in_score),
        .cand_idx   (cnt),
        .best_score (best_score),
        .best_idx   (best_idx),
        .first      (cnt == '0),
        .next_score (next_score),
        .next_idx   (next_idx)
    );

`ifdef CLASS_ARGMAX_SCORE_OUT_EN
    logic signed [SCORE_W-1:0] out_score_q;
    assign bus.out_score = out_score_q;
`endif

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_class = out_class_q;

    always_ff @(posedge clk or negedge GlobalReset) begin
        if (!GlobalReset) begin
            state       <= ARM;
            cnt         <= '0;
            best_score  <= '0;
            best_idx    <= '0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_class_q <= '0;
`ifdef CLASS_ARGMAX_SCORE_OUT_EN
            out_score_q <= '0;
`endif
        end else if (bus.clear) begin
            // flush wins over any same-cycle accept or output handshake
            state       <= ACCUM;
            cnt         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            case (state)
                ARM: begin
                    in_ready_q <= 1'b1;
                    state      <= ACCUM;
                end
                ACCUM: begin
                    if (accept) begin
                        best_score <= next_score;
                        best_idx   <= next_idx;
                        if (cnt == LAST_IDX) begin
                            out_class_q <= next_idx;
`ifdef CLASS_ARGMAX_SCORE_OUT_EN
                            out_score_q <= next_score;
`endif
                            out_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            cnt         <= '0;
                            state       <= DONE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (out_valid_q && bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state       <= ACCUM;
                    end
                end
                default: begin
                    state <= ARM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_class_argmax.sv
// Randomised scoreboard bench for class_argmax; the reference argmax works on whole images.
// Also checks out_score when CLASS_ARGMAX_SCORE_OUT_EN is defined.
module tb_class_argmax;
    import nn_pkg::*;

    localparam int N  = 10;
    localparam int SW = 26;
    localparam int IW = 4;

    typedef logic signed [SW-1:0] sc_t;
    typedef struct {
        int  cls;
        sc_t score;
    } result_t;

    logic clk = 1'b0;
    logic GlobalReset = 1'b0;

    class_argmax_if #(.SCORE_W(SW), .IDX_W(IW)) bus();

    class_argmax #(
        .N_CLASSES (N),
        .SCORE_W   (SW),
        .IDX_W     (IW)
    ) dut (
        .clk         (clk),
        .GlobalReset (GlobalReset),
        .bus         (bus)
    );

    always #5 clk = ~clk;

    result_t expQ[$];
    sc_t     partial[$];
    int      testsRun = 0;
    int      testsFailed = 0;
    bit      randReady = 1'b0;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        testsRun++;
        if (actual != expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Reference: first occurrence of the maximum wins
    function automatic result_t argmaxOf(input sc_t q[$]);
        result_t r;
        r.cls   = 0;
        r.score = q[0];
        for (int i = 1; i < q.size(); i++) begin
            if (q[i] > r.score) begin
                r.cls   = i;
                r.score = q[i];
            end
        end
        return r;
    endfunction

    function automatic sc_t randScore();
        logic [31:0] r;
        r = $urandom;
        case ($urandom % 3)
            0:       return sc_t'(r[SW-1:0]);
            1:       return sc_t'(int'($urandom % 5) - 2);
            default: return (r[0]) ? sc_t'(26'h1FFFFFF) : sc_t'(26'h2000000);
        endcase
    endfunction

    task automatic applyStimulus(input sc_t s, input int gap);
        bit accepted;
        accepted = 1'b0;
        bus.in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_score = s;
        for (int c = 0; c < 200 && !accepted; c++) begin
            @(negedge clk);
            if (bus.in_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!accepted) begin
            checkOutput("accept_timeout", 0, 1);
        end else begin
            partial.push_back(s);
            if (partial.size() == N) begin
                expQ.push_back(argmaxOf(partial));
                partial.delete();
            end
        end
    endtask

    task automatic sendImage(input sc_t img[$], input int gapMax);
        foreach (img[i]) applyStimulus(img[i], (gapMax > 0) ? int'($urandom % (gapMax + 1)) : 0);
    endtask

    // Monitor: pops the scoreboard on every output handshake
    always @(negedge clk) begin
        result_t r;
        if (GlobalReset) begin
            if (bus.in_ready && bus.out_valid) checkOutput("ready_valid_exclusive", 1, 0);
            if (bus.out_valid && bus.out_ready) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected_output", 1, 0);
                end else begin
                    r = expQ.pop_front();
                    checkOutput("out_class", longint'(bus.out_class), r.cls);
`ifdef CLASS_ARGMAX_SCORE_OUT_EN
                    checkOutput("out_score", longint'(bus.out_score), longint'(r.score));
`endif
                end
            end
        end
    end

    always @(posedge clk) begin
        if (randReady) begin
            #1;
            bus.out_ready = ($urandom % 2) == 1;
        end
    end

    initial begin
        sc_t img1[$];
        sc_t img2[$];
        sc_t imgNeg[$];
        sc_t imgMax9[$];
        sc_t imgR[$];

        img1 = '{sc_t'(5), -sc_t'(3), sc_t'(100), sc_t'(7), sc_t'(100),
                 sc_t'(0), -sc_t'(50), sc_t'(2), sc_t'(99), sc_t'(1)};
        img2 = '{-sc_t'(8), sc_t'(3), sc_t'(3), -sc_t'(1), sc_t'(2),
                 sc_t'(0), sc_t'(1), -sc_t'(100), sc_t'(3), sc_t'(2)};
        for (int i = 0; i < N; i++) imgNeg.push_back(sc_t'(26'h2000000));
        imgMax9 = imgNeg;
        imgMax9[N-1] = sc_t'(26'h1FFFFFF);

        bus.clear     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_score  = '0;
        bus.out_ready = 1'b1;

        // Reset values, then release between edges
        repeat (2) @(posedge clk);
        #3;
        checkOutput("reset_in_ready", longint'(bus.in_ready), 0);
        checkOutput("reset_out_valid", longint'(bus.out_valid), 0);
        checkOutput("reset_out_class", longint'(bus.out_class), 0);
        GlobalReset = 1'b1;
        @(negedge clk);
        checkOutput("pre_arm_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("arm_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Back-to-back image, tie keeps the lower index
        sendImage(img1, 0);
        @(negedge clk);
        checkOutput("latency_out_valid", longint'(bus.out_valid), 1);
        checkOutput("tie_out_class", longint'(bus.out_class), 2);
        checkOutput("done_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        #1;

        // Signed extremes
        sendImage(imgNeg, 0);
        @(negedge clk);
        checkOutput("all_min_class", longint'(bus.out_class), 0);
        @(posedge clk);
        #1;
        sendImage(imgMax9, 0);
        @(negedge clk);
        checkOutput("max_at_9_class", longint'(bus.out_class), 9);
        @(posedge clk);
        #1;

        // Consumer stalls; stray in_valid pulses must be ignored
        bus.out_ready = 1'b0;
        sendImage(img1, 0);
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = ($urandom % 2) == 1;
            bus.in_score = sc_t'($urandom);
            @(negedge clk);
            checkOutput("hold_out_valid", longint'(bus.out_valid), 1);
            checkOutput("hold_out_class", longint'(bus.out_class), 2);
            checkOutput("hold_in_ready", longint'(bus.in_ready), 0);
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("rearm_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;

        // Clear after four scores, colliding with a score that must be dropped
        for (int i = 0; i < 4; i++) applyStimulus(img1[i], 0);
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in_score = sc_t'(26'h1FFFFFF);
        @(posedge clk);
        #1;
        bus.clear    = 1'b0;
        bus.in_valid = 1'b0;
        partial.delete();
        @(negedge clk);
        checkOutput("clear_out_valid", longint'(bus.out_valid), 0);
        checkOutput("clear_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        sendImage(img2, 0);
        @(negedge clk);
        checkOutput("after_clear_class", longint'(bus.out_class), 1);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of an image
        for (int i = 0; i < 5; i++) applyStimulus(img2[i], 0);
        #2;
        GlobalReset = 1'b0;
        #1;
        checkOutput("async_rst_in_ready", longint'(bus.in_ready), 0);
        checkOutput("async_rst_out_valid", longint'(bus.out_valid), 0);
        checkOutput("async_rst_out_class", longint'(bus.out_class), 0);
        partial.delete();
        @(posedge clk);
        #3;
        GlobalReset = 1'b1;
        @(negedge clk);
        checkOutput("rst_release_in_ready", longint'(bus.in_ready), 0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("rst_arm_in_ready", longint'(bus.in_ready), 1);
        @(posedge clk);
        #1;
        sendImage(img1, 0);
        @(negedge clk);
        checkOutput("post_rst_class", longint'(bus.out_class), 2);
        @(posedge clk);
        #1;

        // Gapped input, then fully random images with random back-pressure
        sendImage(img1, 1);
        sendImage(img2, 1);
        randReady = 1'b1;
        for (int n = 0; n < 25; n++) begin
            imgR.delete();
            for (int i = 0; i < N; i++) imgR.push_back(randScore());
            sendImage(imgR, 1);
        end
        randReady = 1'b0;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 100 && expQ.size() > 0; c++) @(posedge clk);
        @(negedge clk);
        checkOutput("scoreboard_drained", longint'(expQ.size()), 0);

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
